uart_cmd_tx_arbiter: RTL

- Shares the single UART transmit channel between NUM_REQ command requesters (button panel, script player, debug, etc.).
- Arbitrates round-robin and frames one command byte per grant.
- For operation commands, holds the channel until the host returns a FEEDBACK byte or a timeout expires.
- Sits between requesters and the UART TX byte interface; taps the UART RX byte stream for acknowledgement.

---
 rtl/uart_cmd_tx_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_cmd_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX byte channel between NUM_REQ
// command requesters and, for OPERATE commands, waits for host feedback.
module uart_cmd_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [1:0]  FEEDBACK       = 2'b01,
  parameter logic [1:0]  OPERATE        = 2'b10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 busy,
  output logic                 ack_ok,
  output logic                 timeout_err,
  output logic [3:0]           last_feedback
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, GAP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic          found;
  int unsigned   cand;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    req_byte [NUM_REQ];
  logic          gap_done;
  logic          timer_done;
  logic          fb_hit;
  logic          unused_rx_bits;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_byte
    assign req_byte[g] = req_data[8*g +: 8];
  end

  // First requesting index at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        sel   = cand[PW-1:0];
      end
    end
  end

  // Grant is decided in the IDLE cycle itself; rst_n gating keeps it low during reset.
  always_comb begin
    grant = '0;
    if (rst_n && state == IDLE && found) grant[sel] = 1'b1;
  end

  assign busy           = (state != IDLE);
  assign gap_done       = (32'(gap_cnt) + 32'd1) >= GAP_CYCLES;
  assign timer_done     = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign fb_hit         = rx_valid && (rx_data[1:0] == FEEDBACK);
  assign unused_rx_bits = &{1'b0, rx_data[7:6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      timer         <= '0;
      gap_cnt       <= '0;
      ack_ok        <= 1'b0;
      timeout_err   <= 1'b0;
      last_feedback <= '0;
    end else begin
      ack_ok      <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            tx_data  <= req_byte[sel];
            tx_valid <= 1'b1;
            ptr      <= (32'(sel) + 32'd1 == NUM_REQ) ? '0 : sel + 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (tx_data[1:0] == OPERATE) begin
              timer <= '0;
              state <= WAIT_ACK;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        WAIT_ACK: begin
          // Feedback is tested first so it wins over a coincident timeout.
          if (fb_hit) begin
            ack_ok        <= 1'b1;
            last_feedback <= rx_data[5:2];
            gap_cnt       <= '0;
            state         <= GAP;
          end else if (timer_done) begin
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state       <= GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          if (gap_done) state <= IDLE;
          else          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
